// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
// State encoding, counter sizing and status field widths.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLLRST,
    WAIT,
    SETTLE,
    RUN,
    FAULT
  } state_e;

  localparam int RETRY_W = 4;
  localparam int LOSS_W  = 8;

  function automatic int cnt_width(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level.
// Output follows the input after STAGES clock edges.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: pulses PLL reset, waits for stable lock,
// then releases the core reset; re-enters bring-up on lock loss.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int SETTLE_CYCLES  = 1024,
  parameter int MAX_RETRIES    = 8,
  parameter int SYNC_STAGES    = 2
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              pll_locked,
  output logic              pll_rst,
  output logic              sys_reset,
  output logic              ready,
  output logic [RETRY_W-1:0] retry_count,
  output logic [LOSS_W-1:0]  lock_loss_count,
  output logic              fault
);

  localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);

  localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRIES - 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [LOSS_W-1:0]  loss_q, loss_d;
  logic               pll_rst_q, sys_reset_q, ready_q, fault_q;
  logic               locked_s;

  sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i(refclk),
    .rst_i(rst),
    .d_i  (pll_locked),
    .q_o  (locked_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    retry_d = retry_q;
    loss_d  = loss_q;
    unique case (state_q)
      PLLRST: begin
        if (cnt_q == RST_LAST) state_d = WAIT;
      end
      WAIT: begin
        // A lock seen on the timeout cycle takes priority over a retry.
        if (locked_s) begin
          state_d = SETTLE;
        end else if (cnt_q == TO_LAST) begin
          retry_d = retry_q + 1'b1;
          state_d = (retry_q == RETRY_LAST) ? FAULT : PLLRST;
        end
      end
      SETTLE: begin
        if (!locked_s) state_d = WAIT;
        else if (cnt_q == SET_LAST) state_d = RUN;
      end
      RUN: begin
        cnt_d   = cnt_q;
        retry_d = '0;
        if (!locked_s) begin
          state_d = PLLRST;
          if (loss_q != '1) loss_d = loss_q + 1'b1;
        end
      end
      FAULT: begin
        cnt_d = cnt_q;
      end
      default: begin
        state_d = PLLRST;
      end
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q     <= PLLRST;
      cnt_q       <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_rst_q   <= 1'b1;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pll_rst_q   <= (state_q == PLLRST);
      sys_reset_q <= (state_q != RUN);
      ready_q     <= (state_q == RUN);
      fault_q     <= (state_q == FAULT);
    end
  end

  assign pll_rst         = pll_rst_q;
  assign sys_reset       = sys_reset_q;
  assign ready           = ready_q;
  assign retry_count     = retry_q;
  assign lock_loss_count = loss_q;
  assign fault           = fault_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small timing parameters.
// Expected values queue up before each step and are checked on observation.
module tb_pll_reset_sequencer;

  localparam int P_RST    = 4;
  localparam int P_TO     = 20;
  localparam int P_SET    = 8;
  localparam int P_RETRY  = 3;
  localparam int P_SYNC   = 2;

  localparam int C_PRST_LO = 0;
  localparam int C_PRST_HI = 1;
  localparam int C_SYS_LO  = 2;
  localparam int C_SYS_HI  = 3;
  localparam int C_FAULT   = 4;
  localparam int C_READY   = 5;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b1;
  logic       pll_rst;
  logic       sys_reset;
  logic       ready;
  logic [3:0] retry_count;
  logic [7:0] lock_loss_count;
  logic       fault;

  typedef struct {
    string tag;
    int    exp;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   n;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES(P_RST),
    .LOCK_TIMEOUT  (P_TO),
    .SETTLE_CYCLES (P_SET),
    .MAX_RETRIES   (P_RETRY),
    .SYNC_STAGES   (P_SYNC)
  ) dut (
    .refclk         (refclk),
    .rst            (rst),
    .pll_locked     (pll_locked),
    .pll_rst        (pll_rst),
    .sys_reset      (sys_reset),
    .ready          (ready),
    .retry_count    (retry_count),
    .lock_loss_count(lock_loss_count),
    .fault          (fault)
  );

  always #5 refclk = ~refclk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push(input string tag, input int exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input int obs);
    exp_t e;
    n_chk++;
    if (sb.size() == 0) begin
      $error("FAIL sb_underflow: got %0d want none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) n_pass++;
      else $error("FAIL %s: got %0d want %0d", e.tag, obs, e.exp);
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    push(tag, exp);
    pop_chk(obs);
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge refclk);
    #1;
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      C_PRST_LO: return pll_rst == 1'b0;
      C_PRST_HI: return pll_rst == 1'b1;
      C_SYS_LO:  return sys_reset == 1'b0;
      C_SYS_HI:  return sys_reset == 1'b1;
      C_FAULT:   return fault == 1'b1;
      C_READY:   return ready == 1'b1;
      default:   return 1'b0;
    endcase
  endfunction

  // Edges until the condition is first seen; 0 means it never came.
  task automatic meas(input int sel, output int cnt);
    int i;
    cnt = 0;
    i = 0;
    while (cnt == 0 && i < 200) begin
      i++;
      @(posedge refclk);
      #1;
      if (cond(sel)) cnt = i;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pll_rst"}, int'(pll_rst), 1);
    chk({tag, "_sys_reset"}, int'(sys_reset), 1);
    chk({tag, "_ready"}, int'(ready), 0);
    chk({tag, "_retry"}, int'(retry_count), 0);
    chk({tag, "_loss"}, int'(lock_loss_count), 0);
    chk({tag, "_fault"}, int'(fault), 0);
  endtask

  initial begin
    // Power-up with lock already present.
    rst = 1'b1;
    pll_locked = 1'b1;
    step(3);
    chk_reset_vals("por");
    rst = 1'b0;
    push("t1_pllrst_fall", P_RST + 1);
    meas(C_PRST_LO, n);
    pop_chk(n);
    push("t1_sys_fall", P_SET + 1);
    meas(C_SYS_LO, n);
    pop_chk(n);
    chk("t1_ready", int'(ready), 1);
    chk("t1_retry", int'(retry_count), 0);
    chk("t1_loss", int'(lock_loss_count), 0);

    // Three-cycle lock drop in RUN.
    pll_locked = 1'b0;
    step(3);
    chk("t4_sys_still_lo", int'(sys_reset), 0);
    pll_locked = 1'b1;
    step(1);
    chk("t4_sys_hi", int'(sys_reset), 1);
    chk("t4_ready_lo", int'(ready), 0);
    chk("t4_pll_rst_hi", int'(pll_rst), 1);
    chk("t4_loss1", int'(lock_loss_count), 1);
    push("t4_pulse", P_RST);
    meas(C_PRST_LO, n);
    pop_chk(n);
    push("t4_relock", P_SET + 1);
    meas(C_SYS_LO, n);
    pop_chk(n);

    // Many more drops to reach saturation.
    for (int k = 0; k < 300; k++) begin
      pll_locked = 1'b0;
      step(3);
      pll_locked = 1'b1;
      meas(C_READY, n);
      if (n == 0) chk("t4_relock_loop", n, 1);
    end
    chk("t4_loss_sat", int'(lock_loss_count), 255);

    // Permanent loss from RUN: retries then fault.
    pll_locked = 1'b0;
    push("t2_drop", 4);
    meas(C_PRST_HI, n);
    pop_chk(n);
    chk("t2_loss_hold", int'(lock_loss_count), 255);
    chk("t2_retry0", int'(retry_count), 0);
    push("t2_pulse0", P_RST);
    meas(C_PRST_LO, n);
    pop_chk(n);
    push("t2_to1", P_TO);
    meas(C_PRST_HI, n);
    pop_chk(n);
    chk("t2_retry1", int'(retry_count), 1);
    push("t2_pulse1", P_RST);
    meas(C_PRST_LO, n);
    pop_chk(n);
    push("t2_to2", P_TO);
    meas(C_PRST_HI, n);
    pop_chk(n);
    chk("t2_retry2", int'(retry_count), 2);
    push("t2_pulse2", P_RST);
    meas(C_PRST_LO, n);
    pop_chk(n);
    push("t2_to3", P_TO);
    meas(C_FAULT, n);
    pop_chk(n);
    chk("t2_retry3", int'(retry_count), P_RETRY);
    chk("t2_sys", int'(sys_reset), 1);
    chk("t2_pll_rst", int'(pll_rst), 0);
    pll_locked = 1'b1;
    step(10);
    chk("t2_fault_sticky", int'(fault), 1);
    chk("t2_sys_sticky", int'(sys_reset), 1);
    chk("t2_ready_lo", int'(ready), 0);
    chk("t2_pll_rst_lo", int'(pll_rst), 0);
    chk("t2_retry_hold", int'(retry_count), P_RETRY);

    // One-cycle rst while in FAULT.
    rst = 1'b1;
    step(1);
    chk_reset_vals("t6f");
    rst = 1'b0;
    push("t6f_restart", P_RST + 1 + P_SET + 1);
    meas(C_SYS_LO, n);
    pop_chk(n);

    // One-cycle rst while in SETTLE.
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(8);
    chk("t6s_in_settle", int'(sys_reset), 1);
    rst = 1'b1;
    step(1);
    chk_reset_vals("t6s");
    rst = 1'b0;
    push("t6s_restart", P_RST + 1 + P_SET + 1);
    meas(C_SYS_LO, n);
    pop_chk(n);

    // Single-cycle lock glitch at SETTLE count 5.
    pll_locked = 1'b0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    push("t3_pllrst_fall", P_RST + 1);
    meas(C_PRST_LO, n);
    pop_chk(n);
    pll_locked = 1'b1;
    step(6);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    step(3);
    chk("t3_sys_hi", int'(sys_reset), 1);
    chk("t3_retry", int'(retry_count), 0);
    push("t3_full_settle", P_SET + 1);
    meas(C_SYS_LO, n);
    pop_chk(n);

    // Lock arrives on the timeout cycle.
    pll_locked = 1'b0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    push("t5_pllrst_fall", P_RST + 1);
    meas(C_PRST_LO, n);
    pop_chk(n);
    step(P_TO - P_SYNC - 2);
    pll_locked = 1'b1;
    step(4);
    chk("t5_no_pulse", int'(pll_rst), 0);
    chk("t5_retry", int'(retry_count), 0);
    push("t5_settle", P_SET);
    meas(C_SYS_LO, n);
    pop_chk(n);
    chk("t5_ready", int'(ready), 1);

    if (sb.size() != 0) begin
      n_chk++;
      $error("FAIL sb_leftover: got %0d want 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
